// File: rtl/dac_ctrl_pkg.sv
// Shared types and constants for the parallel DAC write path: FSM encoding,
// pin idle levels and the default strobe timing.
package dac_ctrl_pkg;

  localparam int SAMPLE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_LOAD
  } dac_state_t;

  localparam logic                PIN_IDLE   = 1'b1;
  localparam logic                PIN_ACTIVE = 1'b0;
  localparam logic [SAMPLE_W-1:0] DATA_IDLE  = '0;

  localparam int DEF_SETUP_CYCLES  = 1;
  localparam int DEF_WR_LOW_CYCLES = 3;
  localparam int DEF_HOLD_CYCLES   = 1;
  localparam int DEF_LDAC_CYCLES   = 2;

  function automatic int write_cycles(input int setup, input int wr_low,
                                      input int hold, input int ldac);
    return setup + wr_low + hold + ldac;
  endfunction

  localparam int WRITE_CYCLES = write_cycles(DEF_SETUP_CYCLES, DEF_WR_LOW_CYCLES,
                                             DEF_HOLD_CYCLES, DEF_LDAC_CYCLES);

endpackage

// File: rtl/dac_write_control_if.sv
// Sample stream into the DAC writer: valid/ready handshake with 8-bit data.
interface dac_write_control_if;
  import dac_ctrl_pkg::*;

  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample_data;
  logic                sample_ready;

  modport master (output sample_valid, output sample_data, input sample_ready);
  modport slave  (input sample_valid, input sample_data, output sample_ready);

endinterface

// File: rtl/dac_sample_fifo.sv
// Small synchronous sample FIFO; head is visible combinationally, pop consumes it.
// Push when full and pop when empty are ignored.
module dac_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_100M,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_100M) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is read until the count says it was written.
  always_ff @(posedge clk_100M) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dac_write_control.sv
// Paced writer for an 8-bit parallel DAC: one CS/WR write plus LDAC update per period.
// Optional saturating underrun counter when DAC_UNDERRUN_CNT_EN is defined.
module dac_write_control
  import dac_ctrl_pkg::*;
#(
  parameter int UPDATE_PERIOD = 100,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int WR_LOW_CYCLES = DEF_WR_LOW_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int LDAC_CYCLES   = DEF_LDAC_CYCLES
) (
  input  logic                clk_100M,
  input  logic                reset,
  input  logic                DAC_ready,
  dac_write_control_if.slave  smp,
  output logic [SAMPLE_W-1:0] DAC_Data,
  output logic                CS,
  output logic                WR,
  output logic                LDAC,
  output logic                underrun
`ifdef DAC_UNDERRUN_CNT_EN
  ,
  output logic [15:0]         underrun_count
`endif
);

  localparam int PCW       = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam int SCW       = 8;
  localparam int WR_CYCLES = write_cycles(SETUP_CYCLES, WR_LOW_CYCLES, HOLD_CYCLES, LDAC_CYCLES);

  logic [PCW-1:0]      period_cnt;
  logic                tick;
  dac_state_t          state;
  logic [SCW-1:0]      step_cnt;
  logic                fifo_full;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] fifo_head;
  logic                push;
  logic                pop;

  assign push             = smp.sample_valid && !fifo_full;
  assign smp.sample_ready = !fifo_full;
  assign tick             = (period_cnt == '0) && DAC_ready;
  assign pop              = tick && (state == ST_IDLE) && !fifo_empty;

  dac_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk_100M  (clk_100M),
    .reset     (reset),
    .push      (push),
    .push_data (smp.sample_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Parked at zero while the DAC is down, so the first tick lands right after it comes up.
  always_ff @(posedge clk_100M) begin
    if (reset || !DAC_ready) begin
      period_cnt <= '0;
    end else if (period_cnt == PCW'(UPDATE_PERIOD - 1)) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_100M) begin
    if (reset) begin
      state    <= ST_IDLE;
      step_cnt <= '0;
      DAC_Data <= DATA_IDLE;
      CS       <= PIN_IDLE;
      WR       <= PIN_IDLE;
      LDAC     <= PIN_IDLE;
      underrun <= 1'b0;
    end else begin
      underrun <= tick && fifo_empty;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            DAC_Data <= fifo_head;
            CS       <= PIN_ACTIVE;
            step_cnt <= SCW'(SETUP_CYCLES - 1);
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (step_cnt == '0) begin
            WR       <= PIN_ACTIVE;
            step_cnt <= SCW'(WR_LOW_CYCLES - 1);
            state    <= ST_STROBE;
          end else begin
            step_cnt <= step_cnt - 1'b1;
          end
        end
        ST_STROBE: begin
          if (step_cnt == '0) begin
            WR       <= PIN_IDLE;
            step_cnt <= SCW'(HOLD_CYCLES - 1);
            state    <= ST_HOLD;
          end else begin
            step_cnt <= step_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (step_cnt == '0) begin
            CS       <= PIN_IDLE;
            LDAC     <= PIN_ACTIVE;
            step_cnt <= SCW'(LDAC_CYCLES - 1);
            state    <= ST_LOAD;
          end else begin
            step_cnt <= step_cnt - 1'b1;
          end
        end
        ST_LOAD: begin
          if (step_cnt == '0) begin
            LDAC  <= PIN_IDLE;
            state <= ST_IDLE;
          end else begin
            step_cnt <= step_cnt - 1'b1;
          end
        end
        default: begin
          CS    <= PIN_IDLE;
          WR    <= PIN_IDLE;
          LDAC  <= PIN_IDLE;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DAC_UNDERRUN_CNT_EN
  always_ff @(posedge clk_100M) begin
    if (reset) begin
      underrun_count <= '0;
    end else if (tick && fifo_empty && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

  // A full write must always fit inside one period, so ticks only ever see IDLE.
  always @(posedge clk_100M) begin
    if (!reset) begin
      assert (UPDATE_PERIOD >= WR_CYCLES + 2);
      assert (!(tick && (state != ST_IDLE)));
    end
  end

endmodule
